lane_frame_ctrl: RTL and testbench

LANE_FRAME_CTRL -- requirements
Module: lane_frame_ctrl

---
 rtl/lane_pkg.sv | 21 ++
 rtl/lane_hold_filter.sv | 58 +++++
 rtl/lane_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_lane_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared state, lane record and absent-lane constant for lane_frame_ctrl
package lane_pkg;

   localparam int LANE_THETA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CANNY,
      ST_HOUGH,
      ST_FILTER,
      ST_HIGHLIGHT
   } state_t;

   typedef struct packed {
      logic signed [15:0]      rho;
      logic [LANE_THETA_W-1:0] theta;
   } lane_t;

   localparam lane_t LANE_ABSENT = '0;

endpackage

// File: rtl/lane_hold_filter.sv
// rtl/lane_hold_filter.sv - per-lane filter: pass present lanes, hold the last valid one for a bounded number of frames
module lane_hold_filter
   import lane_pkg::*;
#(
   parameter int HOLD_FRAMES = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_en,
   input  logic signed [15:0]       i_rho,
   input  logic [LANE_THETA_W-1:0]  i_theta,
   output logic signed [15:0]       o_rho,
   output logic [LANE_THETA_W-1:0]  o_theta
);

   localparam int CW = $clog2(HOLD_FRAMES + 2);

   lane_t          w_in;
   lane_t          w_out;
   logic           w_present;
   logic           w_use_last;
   lane_t          r_last;
   logic           r_valid;
   logic [CW-1:0]  r_hold;

   // o_rho/o_theta are combinational; the top registers them when leaving FILTER
   always_comb begin
      w_in       = '{rho: i_rho, theta: i_theta};
      w_present  = (w_in != LANE_ABSENT);
      w_use_last = !w_present && r_valid && (r_hold < CW'(HOLD_FRAMES));
      if (w_present)
         w_out = w_in;
      else if (w_use_last)
         w_out = r_last;
      else
         w_out = LANE_ABSENT;
   end

   assign o_rho   = w_out.rho;
   assign o_theta = w_out.theta;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_last  <= LANE_ABSENT;
         r_valid <= 1'b0;
         r_hold  <= '0;
      end else if (i_en) begin
         if (w_present) begin
            r_last  <= w_in;
            r_valid <= 1'b1;
            r_hold  <= '0;
         end else if (w_use_last) begin
            r_hold <= r_hold + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lane_frame_ctrl.sv
// rtl/lane_frame_ctrl.sv - frame sequencer for canny -> hough -> lane filter -> highlight with timeout and drop counting
module lane_frame_ctrl
   import lane_pkg::*;
#(
   parameter int THETA_BITS     = 9,
   parameter int HOLD_FRAMES    = 4,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_frame_start,
   output logic                   o_canny_start,
   input  logic                   i_canny_done,
   output logic                   o_hough_start,
   input  logic                   i_hough_done,
   input  logic signed [15:0]     i_left_rho_in,
   input  logic [THETA_BITS-1:0]  i_left_theta_in,
   input  logic signed [15:0]     i_right_rho_in,
   input  logic [THETA_BITS-1:0]  i_right_theta_in,
   output logic                   o_hl_start,
   output logic signed [15:0]     o_left_rho_out,
   output logic [THETA_BITS-1:0]  o_left_theta_out,
   output logic signed [15:0]     o_right_rho_out,
   output logic [THETA_BITS-1:0]  o_right_theta_out,
   input  logic                   i_hl_done,
   output logic                   o_busy,
   output logic [15:0]            o_frame_count,
   output logic [7:0]             o_dropped_frames,
   output logic                   o_timeout_err
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t                   r_state;
   logic [31:0]              r_tmo;
   lane_t                    r_left_cap;
   lane_t                    r_right_cap;
   logic                     w_filt_en;
   logic                     w_tmo_hit;
   logic signed [15:0]       w_left_rho;
   logic [LANE_THETA_W-1:0]  w_left_theta;
   logic signed [15:0]       w_right_rho;
   logic [LANE_THETA_W-1:0]  w_right_theta;

   assign w_filt_en = (r_state == ST_FILTER);
   assign w_tmo_hit = (r_tmo == TMO_LAST);
   assign o_busy    = (r_state != ST_IDLE);

   lane_hold_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_left (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_en    (w_filt_en),
      .i_rho   (r_left_cap.rho),
      .i_theta (r_left_cap.theta),
      .o_rho   (w_left_rho),
      .o_theta (w_left_theta)
   );

   lane_hold_filter #(.HOLD_FRAMES(HOLD_FRAMES)) u_right (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_en    (w_filt_en),
      .i_rho   (r_right_cap.rho),
      .i_theta (r_right_cap.theta),
      .o_rho   (w_right_rho),
      .o_theta (w_right_theta)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state           <= ST_IDLE;
         r_tmo             <= '0;
         r_left_cap        <= LANE_ABSENT;
         r_right_cap       <= LANE_ABSENT;
         o_canny_start     <= 1'b0;
         o_hough_start     <= 1'b0;
         o_hl_start        <= 1'b0;
         o_left_rho_out    <= '0;
         o_left_theta_out  <= '0;
         o_right_rho_out   <= '0;
         o_right_theta_out <= '0;
         o_frame_count     <= '0;
         o_dropped_frames  <= '0;
         o_timeout_err     <= 1'b0;
      end else begin
         o_canny_start <= 1'b0;
         o_hough_start <= 1'b0;
         o_hl_start    <= 1'b0;

         if (i_frame_start && (r_state != ST_IDLE) && (o_dropped_frames != 8'hFF))
            o_dropped_frames <= o_dropped_frames + 8'd1;

         // Every transition clears the timeout counter; a done beats a coincident timeout
         case (r_state)
            ST_IDLE: begin
               if (i_frame_start) begin
                  r_state       <= ST_CANNY;
                  o_canny_start <= 1'b1;
                  r_tmo         <= '0;
               end
            end
            ST_CANNY: begin
               if (i_canny_done) begin
                  r_state       <= ST_HOUGH;
                  o_hough_start <= 1'b1;
                  r_tmo         <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= ST_IDLE;
                  o_timeout_err <= 1'b1;
                  r_tmo         <= '0;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
               end
            end
            ST_HOUGH: begin
               if (i_hough_done) begin
                  r_state     <= ST_FILTER;
                  r_left_cap  <= '{rho: i_left_rho_in,  theta: LANE_THETA_W'(i_left_theta_in)};
                  r_right_cap <= '{rho: i_right_rho_in, theta: LANE_THETA_W'(i_right_theta_in)};
                  r_tmo       <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= ST_IDLE;
                  o_timeout_err <= 1'b1;
                  r_tmo         <= '0;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
               end
            end
            ST_FILTER: begin
               r_state           <= ST_HIGHLIGHT;
               o_hl_start        <= 1'b1;
               o_left_rho_out    <= w_left_rho;
               o_left_theta_out  <= THETA_BITS'(w_left_theta);
               o_right_rho_out   <= w_right_rho;
               o_right_theta_out <= THETA_BITS'(w_right_theta);
               r_tmo             <= '0;
            end
            ST_HIGHLIGHT: begin
               if (i_hl_done) begin
                  r_state       <= ST_IDLE;
                  o_frame_count <= o_frame_count + 16'd1;
                  r_tmo         <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= ST_IDLE;
                  o_timeout_err <= 1'b1;
                  r_tmo         <= '0;
               end else begin
                  r_tmo <= r_tmo + 32'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tmo   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_frame_ctrl.sv
// tb/tb_lane_frame_ctrl.sv - self-checking bench for lane_frame_ctrl against a frame-level reference model
module tb_lane_frame_ctrl;

   localparam int THETA_BITS     = 9;
   localparam int HOLD_FRAMES    = 4;
   localparam int TIMEOUT_CYCLES = 100;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   frame_start, canny_done, hough_done, hl_done;
   logic signed [15:0]     lr_in, rr_in;
   logic [THETA_BITS-1:0]  lt_in, rt_in;
   logic                   canny_start, hough_start, hl_start, busy, timeout_err;
   logic signed [15:0]     lr_out, rr_out;
   logic [THETA_BITS-1:0]  lt_out, rt_out;
   logic [15:0]            frame_count;
   logic [7:0]             dropped;

   int vectors = 0;
   int miscompares = 0;
   int n_cs, n_hs, n_hl;

   // frame-level reference state
   logic [15:0]            m_frames;
   int                     m_drops;
   logic                   m_err;
   logic signed [15:0]     m_rho [2];
   logic [THETA_BITS-1:0]  m_th  [2];
   logic                   m_ok  [2];
   int                     m_hold[2];
   logic signed [15:0]     e_lr, e_rr;
   logic [THETA_BITS-1:0]  e_lt, e_rt;

   lane_frame_ctrl #(
      .THETA_BITS(THETA_BITS), .HOLD_FRAMES(HOLD_FRAMES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_frame_start(frame_start),
      .o_canny_start(canny_start), .i_canny_done(canny_done),
      .o_hough_start(hough_start), .i_hough_done(hough_done),
      .i_left_rho_in(lr_in), .i_left_theta_in(lt_in),
      .i_right_rho_in(rr_in), .i_right_theta_in(rt_in),
      .o_hl_start(hl_start),
      .o_left_rho_out(lr_out), .o_left_theta_out(lt_out),
      .o_right_rho_out(rr_out), .o_right_theta_out(rt_out),
      .i_hl_done(hl_done), .o_busy(busy),
      .o_frame_count(frame_count), .o_dropped_frames(dropped),
      .o_timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
      n_cs += int'(canny_start);
      n_hs += int'(hough_start);
      n_hl += int'(hl_start);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset;
      m_frames = '0; m_drops = 0; m_err = 1'b0;
      for (int s = 0; s < 2; s++) begin
         m_rho[s] = '0; m_th[s] = '0; m_ok[s] = 1'b0; m_hold[s] = 0;
      end
   endtask

   task automatic model_lane(input int s, input logic signed [15:0] r, input logic [THETA_BITS-1:0] t,
                             output logic signed [15:0] orr, output logic [THETA_BITS-1:0] ot);
      if (r != 0 || t != 0) begin
         orr = r; ot = t;
         m_rho[s] = r; m_th[s] = t; m_ok[s] = 1'b1; m_hold[s] = 0;
      end else if (m_ok[s] && m_hold[s] < HOLD_FRAMES) begin
         orr = m_rho[s]; ot = m_th[s];
         m_hold[s]++;
      end else begin
         orr = '0; ot = '0;
      end
   endtask

   task automatic add_drops(input int n);
      m_drops = (m_drops + n > 255) ? 255 : m_drops + n;
   endtask

   task automatic rand_lane(input int absent_pct, output logic signed [15:0] r, output logic [THETA_BITS-1:0] t);
      if ($urandom_range(0, 99) < absent_pct) begin
         r = '0; t = '0;
      end else begin
         r = 16'($urandom);
         t = THETA_BITS'($urandom_range(0, 511));
      end
   endtask

   task automatic check_lanes(input string tag);
      check({tag, "_lrho"}, 32'(lr_out), 32'(e_lr));
      check({tag, "_lth"},  32'(lt_out), 32'(e_lt));
      check({tag, "_rrho"}, 32'(rr_out), 32'(e_rr));
      check({tag, "_rth"},  32'(rt_out), 32'(e_rt));
   endtask

   // Runs a frame from frame_start up to the first HIGHLIGHT cycle
   task automatic to_highlight(input logic signed [15:0] lr, input logic [THETA_BITS-1:0] lt,
                               input logic signed [15:0] rr, input logic [THETA_BITS-1:0] rt,
                               input int cd, input int drops, input bit noise);
      n_cs = 0; n_hs = 0; n_hl = 0;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      check("canny_start_latency", 32'(canny_start), 32'd1);
      check("busy_in_canny", 32'(busy), 32'd1);
      for (int i = 0; i < cd; i++) begin
         if (noise) begin
            hough_done = 1'($urandom_range(0, 1));
            hl_done    = 1'($urandom_range(0, 1));
         end
         tick;
         hough_done = 1'b0;
         hl_done    = 1'b0;
      end
      canny_done = 1'b1;
      tick;
      canny_done = 1'b0;
      check("hough_start", 32'(hough_start), 32'd1);
      for (int i = 0; i < drops; i++) begin
         frame_start = 1'b1;
         tick;
      end
      frame_start = 1'b0;
      add_drops(drops);
      lr_in = lr; lt_in = lt; rr_in = rr; rt_in = rt;
      hough_done = 1'b1;
      tick;
      hough_done = 1'b0;
      rand_lane(0, lr_in, lt_in);
      rand_lane(0, rr_in, rt_in);
      model_lane(0, lr, lt, e_lr, e_lt);
      model_lane(1, rr, rt, e_rr, e_rt);
      check("hl_start_not_in_filter", 32'(hl_start), 32'd0);
      tick;
      check("hl_start", 32'(hl_start), 32'd1);
      check_lanes("hl_entry");
   endtask

   task automatic finish_frame(input int hd, input bit race);
      for (int i = 0; i < hd; i++) tick;
      check_lanes("hl_hold");
      hl_done     = 1'b1;
      frame_start = race;
      tick;
      hl_done     = 1'b0;
      frame_start = 1'b0;
      m_frames = m_frames + 16'd1;
      if (race) add_drops(1);
      check("busy_after_hl_done", 32'(busy), 32'd0);
      check("frame_count", 32'(frame_count), 32'(m_frames));
      check("dropped", 32'(dropped), 32'(m_drops));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
      check("n_canny_start", 32'(n_cs), 32'd1);
      check("n_hough_start", 32'(n_hs), 32'd1);
      check("n_hl_start", 32'(n_hl), 32'd1);
      tick;
      check("no_start_after_frame", 32'(canny_start), 32'd0);
      check("idle_after_frame", 32'(busy), 32'd0);
   endtask

   initial begin
      logic signed [15:0]    r0, r1;
      logic [THETA_BITS-1:0] t0, t1;
      int n;

      rst = 1'b1; frame_start = 0; canny_done = 0; hough_done = 0; hl_done = 0;
      lr_in = 0; lt_in = 0; rr_in = 0; rt_in = 0;
      model_reset();
      repeat (3) tick;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_dropped", 32'(dropped), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check("rst_canny_start", 32'(canny_start), 32'd0);
      e_lr = 0; e_lt = 0; e_rr = 0; e_rt = 0;
      check_lanes("rst");
      rst = 1'b0;
      tick;

      // Nominal frame
      to_highlight(16'sd100, 9'd30, -16'sd50, 9'd150, 10, 0, 1'b0);
      check("nominal_lrho", 32'(lr_out), 32'(16'sd100));
      check("nominal_rrho", 32'(rr_out), 32'(-16'sd50));
      finish_frame(20, 1'b0);
      check("nominal_count", 32'(frame_count), 32'd1);

      // Lane hold: one valid left lane, then five absent
      to_highlight(16'sd200, 9'd45, 16'sd7, 9'd9, 2, 0, 1'b0);
      finish_frame(3, 1'b0);
      for (int f = 0; f < 5; f++) begin
         rand_lane(0, r1, t1);
         to_highlight(16'sd0, 9'd0, r1, t1, 1, 0, 1'b0);
         if (f < 4) check("hold_left_rho", 32'(lr_out), 32'(16'sd200));
         else       check("hold_expired_rho", 32'(lr_out), 32'd0);
         finish_frame(2, 1'b0);
      end

      // Randomized frames with noise on the other done inputs, drops and races
      for (int f = 0; f < 10; f++) begin
         rand_lane(40, r0, t0);
         rand_lane(40, r1, t1);
         to_highlight(r0, t0, r1, t1, $urandom_range(0, 15), $urandom_range(0, 5), 1'b1);
         finish_frame($urandom_range(0, 20), 1'($urandom_range(0, 1)));
      end

      // Done inputs while idle are ignored
      canny_done = 1; hough_done = 1; hl_done = 1;
      tick;
      canny_done = 0; hough_done = 0; hl_done = 0;
      tick;
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_starts", 32'(canny_start | hough_start | hl_start), 32'd0);
      check("idle_done_count", 32'(frame_count), 32'(m_frames));

      // Saturating drop counter across four frames of drops in HOUGH
      for (int f = 0; f < 4; f++) begin
         rand_lane(30, r0, t0);
         rand_lane(30, r1, t1);
         to_highlight(r0, t0, r1, t1, 3, 75, 1'b0);
         finish_frame(4, 1'b0);
      end
      check("drop_saturated", 32'(dropped), 32'd255);

      // Done and timeout in the same cycle: done wins
      to_highlight(16'sd11, 9'd22, 16'sd33, 9'd44, TIMEOUT_CYCLES - 1, 0, 1'b0);
      finish_frame(5, 1'b0);

      // Timeout in CANNY
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      n = 0;
      while (busy && n < 10 * TIMEOUT_CYCLES) begin
         n++;
         tick;
      end
      m_err = 1'b1;
      check("timeout_busy_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
      check("timeout_err_set", 32'(timeout_err), 32'd1);
      check("timeout_count_same", 32'(frame_count), 32'(m_frames));

      // Reset in HIGHLIGHT aborts the frame
      to_highlight(16'sd5, 9'd6, 16'sd7, 9'd8, 2, 0, 1'b0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_reset();
      e_lr = 0; e_lt = 0; e_rr = 0; e_rt = 0;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_count", 32'(frame_count), 32'd0);
      check("mrst_dropped", 32'(dropped), 32'd0);
      check("mrst_err", 32'(timeout_err), 32'd0);
      check("mrst_starts", 32'(canny_start | hough_start | hl_start), 32'd0);
      check_lanes("mrst");
      tick;
      check("mrst_no_start_after", 32'(canny_start), 32'd0);
      hl_done = 1'b1;
      tick;
      hl_done = 1'b0;
      tick;
      check("mrst_hl_done_ignored", 32'(frame_count), 32'd0);
      check("mrst_idle", 32'(busy), 32'd0);

      // Filter history was cleared: an absent lane now yields zero
      to_highlight(16'sd0, 9'd0, 16'sd3, 9'd4, 1, 0, 1'b0);
      finish_frame(1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
